random_scheduler: RTL and testbench
===================================

Name: random_scheduler

Overview:
- Shares one 8-bit LFSR random source among NUM_REQ requesters (display digits, effects) using round-robin req/ack arbitration.
- Each grant delivers one 4-bit draw, then steps the LFSR STEPS_PER_DRAW times so consecutive consumers never receive correlated values.
- Supports run-time reseeding.
- Sits between the display/game logic and the random datapath, and is the only block that advances the LFSR.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEED, 8'd1, LFSR value after reset (non-zero).
- STEPS_PER_DRAW, 4, LFSR steps performed after each grant (1..15).

Ports:
- clk_in  input  1  system clock.
- reset_n_in  input  1  asynchronous, active-low reset.
- req_in  input  NUM_REQ  per-requester draw request; level, held until ack.
- ack_out  output  NUM_REQ  one-hot, one-cycle grant strobe.
- value_out  output  4  drawn value; valid only while valid_out=1.
- valid_out  output  1  high for exactly the GRANT cycle.
- grant_id_out  output  $clog2(NUM_REQ)  index of the granted requester; valid with valid_out.
- seed_load_in  input  1  one-cycle reseed strobe.
- seed_in  input  8  new seed; sampled when seed_load_in=1.
- busy_out  output  1  high in GRANT and ADVANCE.

Behaviour:
- Reset (async, reset_n_in=0) sets:
  - state=IDLE, LFSR=SEED
  - ack_out=0, valid_out=0, value_out=0, grant_id_out=0, busy_out=0
  - round-robin pointer=NUM_REQ-1, so requester 0 has first priority
  - seed_pending=0
- Reset asserted mid-grant aborts the grant. No ack is issued afterwards for the interrupted draw.
- LFSR step function, applied only in ADVANCE, with f=L[7]:
  - n0=f; n1=L3; n2=L6^f; n3=L2^f
  - n4=L0^f; n5=~(L4&f); n6=L1; n7=L5
- The LFSR never changes outside ADVANCE or reseed.
- FSM IDLE:
  - If seed_pending, load the stored seed into the LFSR, clear seed_pending, stay in IDLE for this cycle and grant nothing.
  - Otherwise, if any req_in bit is set, pick the first set bit searching upward from (pointer+1) mod NUM_REQ, and go to GRANT.
- FSM GRANT (1 cycle):
  - ack_out[w]=1, valid_out=1, value_out=LFSR[3:0], grant_id_out=w.
  - Pointer updates to w.
  - Next state is ADVANCE with step counter=STEPS_PER_DRAW.
- FSM ADVANCE:
  - Step the LFSR once per cycle and decrement the counter.
  - After the step taken with counter=1, go to IDLE.
- Latency: req sampled in IDLE at cycle t gives ack at t+1.
- Throughput: minimum draw period is STEPS_PER_DRAW+2 cycles (6 by default).
- Outputs are registered. ack_out and valid_out deassert in every state other than GRANT.
- A requester that drops req before its ack has withdrawn; no state is kept for it.
- Requesters must drop req the cycle after their ack, otherwise they re-enter arbitration at lowest priority.
- Reseed:
  - seed_load_in=1 in any state latches seed_in and sets seed_pending; a later strobe overwrites it.
  - The seed is applied on the next IDLE cycle and takes priority over pending requests in that cycle.
  - A seed of 8'h00 is accepted unchanged.
- Simultaneous seed_load_in and req in IDLE with no seed pending: the grant proceeds using the current LFSR, and the seed is applied at the next IDLE.

Test Plan:
- Reset release, req_in=4'b0001 → ack_out=0001 one cycle later, value_out=4'h1 (LFSR 8'h01), grant_id_out=0. After 4 ADVANCE cycles the LFSR = 8'h87.
- Second req from requester 0 → value_out=4'h7. Step sequence from 8'h01 is 8'h30, 8'hA0, 8'hBD, 8'h87; the bench model must match it.
- req_in=4'b1111 held; each requester drops req after its ack → grant order 0,1,2,3,0; ack spacing exactly 6 cycles; never two ack bits set.
- seed_load_in with seed_in=8'h5A during ADVANCE, then req → the grant is delayed one IDLE cycle and value_out=4'hA.
- req_in[2] asserted then dropped before the FSM leaves ADVANCE → no ack to requester 2; LFSR unchanged after ADVANCE ends.
- reset_n_in pulsed low during ADVANCE (asynchronous, between clock edges) → outputs 0 immediately; LFSR=SEED; the next draw returns 4'h1.

Source files
------------

// File: rtl/random_scheduler.sv
// Round-robin scheduler sharing one 8-bit LFSR among NUM_REQ requesters.
// Each grant returns LFSR[3:0], then the LFSR is stepped STEPS_PER_DRAW times.
module random_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [7:0]  SEED           = 8'd1,
  parameter int unsigned STEPS_PER_DRAW = 4
) (
  input  logic                       clk_in,
  input  logic                       reset_n_in,
  input  logic [NUM_REQ-1:0]         req_in,
  output logic [NUM_REQ-1:0]         ack_out,
  output logic [3:0]                 value_out,
  output logic                       valid_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
  input  logic                       seed_load_in,
  input  logic [7:0]                 seed_in,
  output logic                       busy_out
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_ADVANCE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_lfsr, w_lfsr_nxt, w_lfsr_step;
  logic               w_f;
  logic [IDW-1:0]     r_ptr, w_ptr_nxt, w_win;
  logic               w_any;
  int unsigned        w_idx;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_seed_pend, w_seed_pend_nxt;
  logic [7:0]         r_seed, w_seed_nxt;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [3:0]         w_value_nxt;
  logic               w_valid_nxt;
  logic [IDW-1:0]     w_gid_nxt;
  logic               w_busy_nxt;

  // One LFSR step, feedback taken from bit 7
  always_comb begin
    w_f         = r_lfsr[7];
    w_lfsr_step = {r_lfsr[5], r_lfsr[1], ~(r_lfsr[4] & w_f), r_lfsr[0] ^ w_f,
                   r_lfsr[2] ^ w_f, r_lfsr[6] ^ w_f, r_lfsr[3], w_f};
  end

  // First active request searching upward from the slot after the last winner
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = (32'(r_ptr) + i) % NUM_REQ;
      if (!w_any && req_in[IDW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = IDW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lfsr_nxt      = r_lfsr;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_seed_pend_nxt = r_seed_pend;
    w_seed_nxt      = r_seed;
    w_ack_nxt       = '0;
    w_value_nxt     = 4'd0;
    w_valid_nxt     = 1'b0;
    w_gid_nxt       = '0;

    case (r_state)
      S_IDLE: begin
        if (r_seed_pend) begin
          w_lfsr_nxt      = r_seed;
          w_seed_pend_nxt = 1'b0;
        end else if (w_any) begin
          w_state_nxt       = S_GRANT;
          w_ack_nxt[w_win]  = 1'b1;
          w_value_nxt       = r_lfsr[3:0];
          w_valid_nxt       = 1'b1;
          w_gid_nxt         = w_win;
        end
      end
      S_GRANT: begin
        w_ptr_nxt   = grant_id_out;
        w_cnt_nxt   = CW'(STEPS_PER_DRAW);
        w_state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        w_lfsr_nxt = w_lfsr_step;
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A new strobe always wins, even in the cycle an older seed is applied
    if (seed_load_in) begin
      w_seed_nxt      = seed_in;
      w_seed_pend_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state      <= S_IDLE;
      r_lfsr       <= SEED;
      r_ptr        <= IDW'(NUM_REQ - 1);
      r_cnt        <= '0;
      r_seed_pend  <= 1'b0;
      r_seed       <= '0;
      ack_out      <= '0;
      value_out    <= 4'd0;
      valid_out    <= 1'b0;
      grant_id_out <= '0;
      busy_out     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_seed_pend  <= w_seed_pend_nxt;
      r_seed       <= w_seed_nxt;
      ack_out      <= w_ack_nxt;
      value_out    <= w_value_nxt;
      valid_out    <= w_valid_nxt;
      grant_id_out <= w_gid_nxt;
      busy_out     <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_random_scheduler.sv
// Bench for random_scheduler: transaction-level model (draw, then jump the LFSR
// ahead by STEPS_PER_DRAW) compared every cycle, plus directed literal checks.
module tb_random_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned STEPS   = 4;

  logic               clk_in = 1'b0;
  logic               reset_n_in = 1'b0;
  logic [NUM_REQ-1:0] req_in = '0;
  logic [NUM_REQ-1:0] ack_out;
  logic [3:0]         value_out;
  logic               valid_out;
  logic [1:0]         grant_id_out;
  logic               seed_load_in = 1'b0;
  logic [7:0]         seed_in = 8'h00;
  logic               busy_out;

  random_scheduler #(.NUM_REQ(NUM_REQ), .SEED(8'h01), .STEPS_PER_DRAW(STEPS)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .req_in(req_in), .ack_out(ack_out),
    .value_out(value_out), .valid_out(valid_out), .grant_id_out(grant_id_out),
    .seed_load_in(seed_load_in), .seed_in(seed_in), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int mode  = 0;   // 0: manual req, 1: drop on ack, 2: all request, drop only on own ack

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic f;
    f = l[7];
    return {l[5], l[1], ~(l[4] & f), l[0] ^ f, l[2] ^ f, l[6] ^ f, l[3], f};
  endfunction

  // Model: a draw takes LFSR[3:0] and jumps the LFSR ahead; the block is then
  // unavailable for 1 + STEPS cycles. A pending seed costs one idle cycle.
  logic [7:0]         m_lfsr = 8'h01;
  int                 m_ptr  = NUM_REQ - 1;
  bit                 m_pend = 1'b0;
  logic [7:0]         m_seed = 8'h00;
  int                 m_busy = 0;
  logic [NUM_REQ-1:0] exp_ack = '0;
  logic               exp_valid = 1'b0;
  logic [3:0]         exp_value = 4'd0;
  logic [1:0]         exp_gid = 2'd0;
  logic               exp_busy = 1'b0;

  always @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      m_lfsr = 8'h01; m_ptr = NUM_REQ - 1; m_pend = 1'b0; m_busy = 0;
      exp_ack = '0; exp_valid = 1'b0; exp_value = 4'd0; exp_gid = 2'd0; exp_busy = 1'b0;
    end else begin
      exp_ack = '0; exp_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
      end else if (m_pend) begin
        m_lfsr = m_seed;
        m_pend = 1'b0;
      end else if (req_in != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_ptr + k) % NUM_REQ;
          if (!exp_valid && req_in[c]) begin
            exp_valid = 1'b1;
            exp_ack[c] = 1'b1;
            exp_gid = 2'(c);
            exp_value = m_lfsr[3:0];
            m_ptr = c;
          end
        end
        for (int s = 0; s < STEPS; s++) m_lfsr = lfsr_step(m_lfsr);
        m_busy = 1 + STEPS;
      end
      if (seed_load_in) begin
        m_seed = seed_in;
        m_pend = 1'b1;
      end
      exp_busy = (m_busy > 0);
    end
  end

  always @(negedge clk_in) begin
    chk("ack", 32'(ack_out), 32'(exp_ack));
    chk("valid", 32'(valid_out), 32'(exp_valid));
    chk("busy", 32'(busy_out), 32'(exp_busy));
    chk("ack_onehot0", 32'($countones(ack_out) <= 1), 32'd1);
    if (exp_valid) begin
      chk("value", 32'(value_out), 32'(exp_value));
      chk("grant_id", 32'(grant_id_out), 32'(exp_gid));
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
    if (mode == 1) req_in = req_in & ~ack_out;
    else if (mode == 2) req_in = 4'hF & ~ack_out;
  endtask

  task automatic wait_ack(input int budget, output int n, output logic [3:0] v,
                          output logic [1:0] g, output logic [3:0] a);
    n = 0;
    v = 4'd0; g = 2'd0; a = '0;
    do begin
      a = ack_out; v = value_out; g = grant_id_out;
      tick();
      n++;
      a = ack_out; v = value_out; g = grant_id_out;
    end while (!valid_out && n < budget);
    if (!valid_out) chk("ack_timeout", 32'(valid_out), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_out && n < 20) begin
      tick();
      n++;
    end
    if (busy_out) chk("idle_timeout", 32'(busy_out), 32'd0);
  endtask

  task automatic bench_reset();
    reset_n_in = 1'b0;
    req_in = '0;
    tick();
    tick();
    reset_n_in = 1'b1;
  endtask

  initial begin
    int n;
    logic [3:0] v;
    logic [1:0] g;
    logic [3:0] a;
    int order [5];
    int gap [5];
    int seen;

    // Pin the model's step function to the hand-computed chain
    chk("step_01", 32'(lfsr_step(8'h01)), 32'h30);
    chk("step_30", 32'(lfsr_step(8'h30)), 32'hA0);
    chk("step_A0", 32'(lfsr_step(8'hA0)), 32'hBD);
    chk("step_BD", 32'(lfsr_step(8'hBD)), 32'h87);

    tick();
    tick();
    chk("reset_ack", 32'(ack_out), 32'd0);
    chk("reset_busy", 32'(busy_out), 32'd0);

    // First draw: latency one cycle, value from seed 8'h01
    reset_n_in = 1'b1;
    mode = 1;
    req_in = 4'b0001;
    wait_ack(10, n, v, g, a);
    chk("first_latency", 32'(n), 32'd1);
    chk("first_ack", 32'(a), 32'b0001);
    chk("first_value", 32'(v), 32'h1);
    chk("first_gid", 32'(g), 32'd0);

    req_in = 4'b0001;
    wait_ack(20, n, v, g, a);
    chk("second_value", 32'(v), 32'h7);
    wait_idle();

    // Round robin with all four requesting continuously
    bench_reset();
    mode = 2;
    req_in = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_ack(20, n, v, g, a);
      order[i] = int'(g);
      gap[i] = n;
    end
    mode = 1;
    req_in = '0;
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));
    for (int i = 1; i < 5; i++) chk($sformatf("rr_gap%0d", i), 32'(gap[i]), 32'd6);
    wait_idle();

    // Reseed during ADVANCE delays the next grant by one idle cycle
    req_in = 4'b0001;
    wait_ack(10, n, v, g, a);
    tick();
    seed_in = 8'h5A;
    seed_load_in = 1'b1;
    req_in = 4'b0001;
    tick();
    seed_load_in = 1'b0;
    wait_ack(20, n, v, g, a);
    chk("seed_gap", 32'(n + 2), 32'd7);
    chk("seed_value", 32'(v), 32'hA);
    wait_idle();

    // Requester 2 withdraws during ADVANCE: no ack, LFSR untouched
    req_in = 4'b0001;
    wait_ack(10, n, v, g, a);
    tick();
    req_in = 4'b0100;
    tick();
    req_in = 4'b0000;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_out) seen++;
    end
    chk("withdraw_no_ack", 32'(seen), 32'd0);
    req_in = 4'b0001;
    wait_ack(10, n, v, g, a);
    chk("after_withdraw_gid", 32'(g), 32'd0);
    chk("after_withdraw_latency", 32'(n), 32'd1);

    // Asynchronous reset between clock edges during ADVANCE
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy_out), 32'd1);
    #2;
    reset_n_in = 1'b0;
    #1;
    chk("async_ack", 32'(ack_out), 32'd0);
    chk("async_valid", 32'(valid_out), 32'd0);
    chk("async_busy", 32'(busy_out), 32'd0);
    chk("async_value", 32'(value_out), 32'd0);
    chk("async_gid", 32'(grant_id_out), 32'd0);
    req_in = '0;
    tick();
    reset_n_in = 1'b1;
    req_in = 4'b0001;
    wait_ack(10, n, v, g, a);
    chk("post_reset_value", 32'(v), 32'h1);
    chk("post_reset_gid", 32'(g), 32'd0);
    wait_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
